// File: rtl/b11_scrambler.sv
// Character scrambler: takes a 6-bit code word when the strobe drops, then runs
// a short add/subtract/modulo-26 sequence with a running key to produce x_out.
module b11_scrambler (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] x_in,
  input  logic       stbi,
  input  logic       __obs,
  output logic [5:0] x_out
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_DATAIN  = 4'd1,
    S_SPAZIO  = 4'd2,
    S_MUL     = 4'd3,
    S_SOMMA   = 4'd4,
    S_RSUM    = 4'd5,
    S_RSOT    = 4'd6,
    S_COMPL   = 4'd7,
    S_DATAOUT = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] r_in_q, r_in_d;
  logic [4:0] cont_q, cont_d;
  logic [8:0] cont1_q, cont1_d;
  logic [5:0] x_out_q, x_out_d;
  logic [8:0] r_ext;
  logic [8:0] cont1_neg;

  // The observation hook deliberately has no effect on the datapath.
  logic unused_obs;
  assign unused_obs = __obs;

  assign r_ext     = {3'b000, r_in_q};
  assign cont1_neg = 9'd0 - cont1_q;

  always_comb begin
    state_d = state_q;
    r_in_d  = r_in_q;
    cont_d  = cont_q;
    cont1_d = cont1_q;
    x_out_d = x_out_q;
    case (state_q)
      S_RESET: begin
        cont_d  = 5'd0;
        r_in_d  = x_in;
        x_out_d = 6'd0;
        state_d = S_DATAIN;
      end
      S_DATAIN: begin
        r_in_d  = x_in;
        state_d = stbi ? S_DATAIN : S_SPAZIO;
      end
      S_SPAZIO: begin
        if (r_in_q == 6'd0 || r_in_q == 6'd63) begin
          cont_d  = (cont_q < 5'd25) ? cont_q + 5'd1 : 5'd0;
          cont1_d = r_ext;
          state_d = S_DATAOUT;
        end else if (r_in_q <= 6'd26) begin
          state_d = S_MUL;
        end else begin
          state_d = S_DATAIN;
        end
      end
      S_MUL: begin
        cont1_d = r_in_q[0] ? {3'b000, cont_q, 1'b0} : {4'b0000, cont_q};
        state_d = S_SOMMA;
      end
      S_SOMMA: begin
        if (r_in_q[1]) begin
          cont1_d = r_ext + cont1_q;
          state_d = S_RSUM;
        end else begin
          cont1_d = r_ext - cont1_q;
          state_d = S_RSOT;
        end
      end
      S_RSUM: begin
        if ($signed(cont1_q) > 9'sd26) begin
          cont1_d = cont1_q - 9'd26;
        end else begin
          state_d = S_COMPL;
        end
      end
      S_RSOT: begin
        // Negative results sit above 63 as unsigned and wrap up into 0..63.
        if (cont1_q > 9'd63) begin
          cont1_d = cont1_q + 9'd26;
        end else begin
          state_d = S_COMPL;
        end
      end
      S_COMPL: begin
        case (r_in_q[3:2])
          2'd0:    cont1_d = cont1_q - 9'd21;
          2'd1:    cont1_d = cont1_q - 9'd42;
          2'd2:    cont1_d = cont1_q + 9'd7;
          default: cont1_d = cont1_q + 9'd28;
        endcase
        state_d = S_DATAOUT;
      end
      S_DATAOUT: begin
        x_out_d = cont1_q[8] ? cont1_neg[5:0] : cont1_q[5:0];
        state_d = S_DATAIN;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_RESET;
      r_in_q  <= 6'd0;
      cont_q  <= 5'd0;
      cont1_q <= 9'd0;
      x_out_q <= 6'd0;
    end else begin
      state_q <= state_d;
      r_in_q  <= r_in_d;
      cont_q  <= cont_d;
      cont1_q <= cont1_d;
      x_out_q <= x_out_d;
    end
  end

  assign x_out = x_out_q;

endmodule

// File: tb/tb_b11_scrambler.sv
// Randomized bench for b11_scrambler against an integer-arithmetic reference
// model of the scrambling rules, including result latency and hold behaviour.
module tb_b11_scrambler;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] x_in;
  logic       stbi;
  logic       obs;
  logic [5:0] x_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cont_m   = 0;
  int exp_x    = 0;

  always #5 clock = ~clock;

  b11_scrambler dut (
    .clock (clock),
    .reset (reset),
    .x_in  (x_in),
    .stbi  (stbi),
    .__obs (obs),
    .x_out (x_out)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    obs = 1'($urandom);
  endtask

  // Reference: result and edges (after the sampling edge) until x_out updates.
  task automatic model_word(input int w, output bit upd, output int res, output int lat);
    int c1, v, it;
    upd = 1'b1;
    it  = 0;
    if (w == 0 || w == 63) begin
      cont_m = (cont_m < 25) ? cont_m + 1 : 0;
      res = w;
      lat = 2;
    end else if (w > 26) begin
      upd = 1'b0;
      res = exp_x;
      lat = 1;
    end else begin
      c1 = (w % 2 == 1) ? 2 * cont_m : cont_m;
      if ((w / 2) % 2 == 1) begin
        v = w + c1;
        while (v > 26) begin v -= 26; it++; end
      end else begin
        v = w - c1;
        while (v < 0) begin v += 26; it++; end
      end
      case ((w / 4) % 4)
        0:       v -= 21;
        1:       v -= 42;
        2:       v += 7;
        default: v += 28;
      endcase
      res = (v < 0 ? -v : v) % 64;
      lat = 6 + it;
    end
  endtask

  // Present one word while the DUT idles in DATAIN and follow it to completion.
  task automatic send_word(input int w, input string tag);
    bit upd;
    int res, lat;
    x_in = 6'(w);
    stbi = 1'b0;
    tick();
    stbi = 1'b1;
    x_in = 6'($urandom);
    model_word(w, upd, res, lat);
    for (int i = 0; i < lat - 1; i++) begin
      tick();
      check_val({tag, "_hold"}, x_out, exp_x);
    end
    tick();
    check_val(tag, x_out, res);
    $display("word %0d upd=%0d -> x_out %0d (expected %0d, latency %0d)", w, upd, x_out, res, lat);
    exp_x = res;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    x_in  = 6'd5;
    stbi  = 1'b1;
    tick();
    tick();
    check_val("reset_xout", x_out, 0);
    cont_m = 0;
    exp_x  = 0;
    reset  = 1'b1;
    tick();
    check_val("reset_state_xout", x_out, 0);
    $display("reset released, x_out %0d", x_out);
  endtask

  initial begin
    reset = 1'b0;
    x_in  = 6'd0;
    stbi  = 1'b1;
    obs   = 1'b0;

    do_reset();
    send_word(5, "basic");
    check_val("basic_const", x_out, 37);
    send_word(63, "key63");
    check_val("key63_const", x_out, 63);
    send_word(3, "key3");
    check_val("key3_const", x_out, 16);
    send_word(40, "out_of_range");
    check_val("oor_const", x_out, 16);
    send_word(0, "zero");
    check_val("zero_const", x_out, 0);

    for (int i = 0; i < 26; i++)
      send_word(($urandom % 2 == 1) ? 63 : 0, "wrap");
    send_word(1, "post_wrap");

    for (int i = 0; i < 10; i++) begin
      stbi = 1'b1;
      x_in = 6'($urandom);
      tick();
      check_val("strobe_hold", x_out, exp_x);
    end
    send_word(22, "strobe_final");

    // Abandon a computation midway through the RSUM loop.
    do_reset();
    send_word(63, "midop_pre63");
    send_word(3, "midop_pre3");
    x_in = 6'd3;
    stbi = 1'b0;
    tick();
    stbi = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    check_val("midop_reset_xout", x_out, 0);
    $display("mid-operation reset, x_out %0d", x_out);
    cont_m = 0;
    exp_x  = 0;
    reset  = 1'b1;
    tick();
    send_word(3, "midop_post");
    check_val("midop_post_const", x_out, 18);

    for (int i = 0; i < 150; i++) begin
      int idle;
      idle = int'($urandom_range(0, 3));
      for (int j = 0; j < idle; j++) begin
        x_in = 6'($urandom);
        tick();
        check_val("idle_hold", x_out, exp_x);
      end
      send_word(int'($urandom_range(0, 63)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
